// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads a 3-byte instruction (opcode + two operands)
// from byte-wide program memory, one byte per completed read, and presents it
// with a one-cycle IR_load pulse. The instruction is committed to the visible
// registers only after the third byte arrives, so an aborted fetch leaves the
// last issued instruction untouched.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_en,
  input  logic       pc_load,
  input  logic [7:0] pc_in,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  input  logic       mem_ready,
  output logic [7:0] opcode,
  output logic [7:0] operando1,
  output logic [7:0] operando2,
  output logic       IR_load,
  output logic [7:0] pc,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_OP  = 3'd1,
    F_A1  = 3'd2,
    F_A2  = 3'd3,
    ISSUE = 3'd4
  } state_e;

  state_e     state_q;
  logic [7:0] pc_q;
  logic [7:0] pc_d;

  // Bytes of the instruction in flight; invisible until the last byte lands.
  logic [7:0] op_stage_q;
  logic [7:0] a1_stage_q;

  // Last fully fetched instruction.
  logic [7:0] opcode_q;
  logic [7:0] operando1_q;
  logic [7:0] operando2_q;

  // Registered copies of the state decodes, updated together with state_q.
  logic       mem_rd_q;
  logic       ir_load_q;
  logic       busy_q;

  // Incremented PC; 8-bit arithmetic wraps FF -> 00 on its own.
  assign pc_d = pc_q + 8'd1;

  // Fetch sequencer: state, PC, staging bytes, committed instruction and
  // the registered status outputs.
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of each other; a blocking = would let pc_q/state_q ordering leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the instruction and staging registers are reset too because
      // the zero value of opcode/operands is architecturally visible.
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      op_stage_q  <= 8'h00;
      a1_stage_q  <= 8'h00;
      opcode_q    <= 8'h00;
      operando1_q <= 8'h00;
      operando2_q <= 8'h00;
      mem_rd_q    <= 1'b0;
      ir_load_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else if (pc_load) begin
      // A jump wins in every state: any partial instruction is dropped and
      // a byte arriving on this same edge is ignored.
      pc_q      <= pc_in;
      state_q   <= IDLE;
      mem_rd_q  <= 1'b0;
      ir_load_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_en) begin
            state_q   <= F_OP;
            mem_rd_q  <= 1'b1;
            ir_load_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        F_OP: begin
          if (mem_ready) begin
            op_stage_q <= mem_data;
            pc_q       <= pc_d;
            state_q    <= F_A1;
            mem_rd_q   <= 1'b1;
            ir_load_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        F_A1: begin
          if (mem_ready) begin
            a1_stage_q <= mem_data;
            pc_q       <= pc_d;
            state_q    <= F_A2;
            mem_rd_q   <= 1'b1;
            ir_load_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        F_A2: begin
          if (mem_ready) begin
            // Last byte: commit the whole instruction in one step.
            opcode_q    <= op_stage_q;
            operando1_q <= a1_stage_q;
            operando2_q <= mem_data;
            pc_q        <= pc_d;
            state_q     <= ISSUE;
            mem_rd_q    <= 1'b0;
            ir_load_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        ISSUE: begin
          if (fetch_en) begin
            state_q   <= F_OP;
            mem_rd_q  <= 1'b1;
            ir_load_q <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            state_q   <= IDLE;
            mem_rd_q  <= 1'b0;
            ir_load_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          mem_rd_q  <= 1'b0;
          ir_load_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign opcode    = opcode_q;
  assign operando1 = operando1_q;
  assign operando2 = operando2_q;
  assign IR_load   = ir_load_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a byte memory with programmable wait states,
// directed stimulus that pushes expected instructions into a scoreboard, and
// a monitor that pops and compares on every IR_load pulse.
module tb_instruction_fetch;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] pc;
  } instr_t;

  logic       clk;
  logic       rst;
  logic       fetch_en;
  logic       pc_load;
  logic [7:0] pc_in;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [7:0] opcode;
  logic [7:0] operando1;
  logic [7:0] operando2;
  logic       IR_load;
  logic [7:0] pc;
  logic       busy;

  logic [7:0] mem [256];
  logic [3:0] wait_cfg;
  logic [3:0] wait_cnt;

  instr_t exp_q[$];
  int     checks;
  int     errors;

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .opcode    (opcode),
    .operando1 (operando1),
    .operando2 (operando2),
    .IR_load   (IR_load),
    .pc        (pc),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data is combinational from the address; ready rises after
  // wait_cfg cycles of an outstanding read.
  assign mem_data  = mem[mem_addr];
  assign mem_ready = mem_rd && (wait_cnt >= wait_cfg);

  always @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= 4'd0;
    else if (mem_rd && !mem_ready) wait_cnt <= wait_cnt + 4'd1;
    else                        wait_cnt <= 4'd0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [7:0] pcv);
    instr_t e;
    e = '{op: op, a1: a1, a2: a2, pc: pcv};
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every IR_load must match the oldest expectation.
  always @(negedge clk) begin
    instr_t e;
    if (!rst && IR_load) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ir_load", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("issued_instr", {opcode, operando1, operando2, pc}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ir_cycle;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h33; mem[8'h04] = 8'h44; mem[8'h05] = 8'h55;
    mem[8'h06] = 8'h66; mem[8'h07] = 8'h77; mem[8'h08] = 8'h88;
    mem[8'h09] = 8'h99; mem[8'h0A] = 8'hAA; mem[8'h0B] = 8'hBB;
    mem[8'h0C] = 8'hE0; mem[8'h0D] = 8'hE1; mem[8'h0E] = 8'hE2;
    mem[8'h40] = 8'hD0; mem[8'h41] = 8'hD1; mem[8'h42] = 8'hD2;
    mem[8'h43] = 8'h5A; mem[8'h44] = 8'h5B; mem[8'h45] = 8'h5C;
    mem[8'hFE] = 8'hC1; mem[8'hFF] = 8'hC2;

    rst      = 1'b1;
    fetch_en = 1'b0;
    pc_load  = 1'b0;
    pc_in    = 8'h00;
    wait_cfg = 4'd0;

    // Reset values, held while rst is high (fetch_en high must be ignored).
    tick();
    fetch_en = 1'b1;
    tick();
    check("rst_busy",   {31'd0, busy},    32'd0);
    check("rst_mem_rd", {31'd0, mem_rd},  32'd0);
    check("rst_irload", {31'd0, IR_load}, 32'd0);
    check("rst_pc",     {24'd0, pc},      32'h00);
    check("rst_instr",  {8'd0, opcode, operando1, operando2}, 32'd0);
    fetch_en = 1'b0;
    rst      = 1'b0;
    tick();
    tick();
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    // Reset-then-fetch, zero wait: IR_load 4 cycles after fetch_en sampled.
    check("a_c0_mem_rd", {31'd0, mem_rd}, 32'd0);
    push(8'hA0, 8'h11, 8'h22, 8'h03);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("a_c1_rd",   {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h00});
    tick();
    check("a_c2_rd",   {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h01});
    tick();
    check("a_c3_rd",   {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h02});
    check("a_c3_noir", {31'd0, IR_load}, 32'd0);
    tick();
    check("a_c4_ir",   {30'd0, IR_load, mem_rd}, {30'd0, 1'b1, 1'b0});
    tick();
    check("a_c5_idle", {23'd0, busy, pc}, {23'd0, 1'b0, 8'h03});

    // Wait states: two wait cycles per byte, address held, IR_load at 10.
    pc_load = 1'b1;
    pc_in   = 8'h00;
    tick();
    pc_load  = 1'b0;
    wait_cfg = 4'd2;
    push(8'hA0, 8'h11, 8'h22, 8'h03);
    fetch_en = 1'b1;
    ir_cycle = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      fetch_en = 1'b0;
      if (c <= 9)
        check("b_addr_hold", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'((c - 1) / 3)});
      if (IR_load) begin
        ir_cycle = c;
        break;
      end
    end
    check("b_ir_cycle", ir_cycle, 32'd10);
    tick();
    check("b_pc", {24'd0, pc}, 32'h03);
    wait_cfg = 4'd0;

    // Wrap-around: fetch from FE reads FE, FF, 00 and leaves pc at 01.
    pc_load = 1'b1;
    pc_in   = 8'hFE;
    tick();
    pc_load = 1'b0;
    check("c_pc_loaded", {23'd0, busy, pc}, {23'd0, 1'b0, 8'hFE});
    push(8'hC1, 8'hC2, 8'hA0, 8'h01);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("c_addr0", {24'd0, mem_addr}, 32'hFE);
    tick();
    check("c_addr1", {24'd0, mem_addr}, 32'hFF);
    tick();
    check("c_addr2", {24'd0, mem_addr}, 32'h00);
    tick();
    tick();
    check("c_pc_after", {24'd0, pc}, 32'h01);

    // Jump during F_A1 while a byte is ready: partial instruction dropped.
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("d_f_op_addr", {24'd0, mem_addr}, 32'h01);
    tick();
    check("d_f_a1_addr", {24'd0, mem_addr}, 32'h02);
    pc_load = 1'b1;
    pc_in   = 8'h40;
    tick();
    pc_load = 1'b0;
    check("d_jump_state", {23'd0, busy, pc}, {23'd0, 1'b0, 8'h40});
    check("d_instr_kept", {8'd0, opcode, operando1, operando2}, {8'd0, 8'hC1, 8'hC2, 8'hA0});
    tick();
    tick();
    check("d_no_ir", {31'd0, IR_load}, 32'd0);
    push(8'hD0, 8'hD1, 8'hD2, 8'h43);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    check("d_refetch_addr", {24'd0, mem_addr}, 32'h40);
    tick();
    tick();
    tick();
    tick();

    // Asynchronous reset between edges during F_A2.
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    tick();
    check("e_in_f_a2", {23'd0, mem_rd, mem_addr}, {23'd0, 1'b1, 8'h45});
    #2 rst = 1'b1;
    #1;
    check("e_async_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("e_async_pc",     {24'd0, pc},     32'h00);
    check("e_async_instr",  {8'd0, opcode, operando1, operando2}, 32'd0);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("e_stay_idle", {30'd0, busy, IR_load}, 32'd0);
    end

    // Streaming with fetch_en held: IR_load every 4th cycle, pc += 3.
    push(8'hA0, 8'h11, 8'h22, 8'h03);
    push(8'h33, 8'h44, 8'h55, 8'h06);
    push(8'h66, 8'h77, 8'h88, 8'h09);
    push(8'h99, 8'hAA, 8'hBB, 8'h0C);
    fetch_en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check("f_ir_cadence", {31'd0, IR_load}, {31'd0, (c % 4) == 0});
    end
    fetch_en = 1'b0;
    tick();
    check("f_end_pc", {23'd0, busy, pc}, {23'd0, 1'b0, 8'h0C});

    // Jump while in ISSUE: the pulse and instruction survive, next is IDLE.
    push(8'hE0, 8'hE1, 8'hE2, 8'h0F);
    fetch_en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("g_issue_ir", {31'd0, IR_load}, 32'd1);
    pc_load = 1'b1;
    pc_in   = 8'h80;
    tick();
    pc_load  = 1'b0;
    fetch_en = 1'b0;
    check("g_after_jump", {23'd0, busy, pc}, {23'd0, 1'b0, 8'h80});
    check("g_instr_valid", {8'd0, opcode, operando1, operando2}, {8'd0, 8'hE0, 8'hE1, 8'hE2});
    tick();
    tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
